// File: rtl/md_pkg.sv
// Shared op codes, FSM states and op-decode helpers for the multiply/divide unit.
package md_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_DIV   = 3'd2,
    MD_DIVU  = 3'd3,
    MD_MTHI  = 3'd4,
    MD_MTLO  = 3'd5
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } md_state_e;

  function automatic logic md_is_iter(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_div(input logic [2:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

  function automatic logic md_is_signed(input logic [2:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

endpackage

// File: rtl/md_sign_fix.sv
// Combinational sign handling: operand magnitudes on entry, result negation on exit.
module md_sign_fix #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  input  logic               i_signed,
  output logic [WIDTH-1:0]   o_mag_a,
  output logic [WIDTH-1:0]   o_mag_b,
  output logic               o_neg_a,
  output logic               o_neg_b,
  input  logic [2*WIDTH-1:0] i_acc,
  input  logic               i_is_div,
  input  logic               i_sa,
  input  logic               i_sb,
  output logic [WIDTH-1:0]   o_hi,
  output logic [WIDTH-1:0]   o_lo
);

  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;

  always_comb begin
    o_neg_a = i_signed & i_a[WIDTH-1];
    o_neg_b = i_signed & i_b[WIDTH-1];
    o_mag_a = o_neg_a ? ('0 - i_a) : i_a;
    o_mag_b = o_neg_b ? ('0 - i_b) : i_b;
  end

  // Remainder follows the dividend's sign; quotient and product follow sa^sb.
  always_comb begin
    w_prod = (i_sa ^ i_sb) ? ('0 - i_acc) : i_acc;
    w_quo  = (i_sa ^ i_sb) ? ('0 - i_acc[WIDTH-1:0]) : i_acc[WIDTH-1:0];
    w_rem  = i_sa ? ('0 - i_acc[2*WIDTH-1:WIDTH]) : i_acc[2*WIDTH-1:WIDTH];
    o_hi   = i_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
    o_lo   = i_is_div ? w_quo : w_prod[WIDTH-1:0];
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; one bit per cycle, stalls via md_busy.
module mul_div_unit
  import md_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             md_start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] md_a,
  input  logic [WIDTH-1:0] md_b,
  input  logic             md_flush,
  output logic             md_busy,
  output logic             md_done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  md_state_e        r_state;
  md_state_e        w_next;
  logic [CW-1:0]    r_cnt;
  logic [2*WIDTH:0] r_acc;
  logic [WIDTH-1:0] r_mcand;
  logic             r_is_div;
  logic             r_sa;
  logic             r_sb;
  logic             r_done;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_accept;
  logic             w_div_zero;
  logic             w_signed;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;
  logic             w_neg_a;
  logic             w_neg_b;
  logic [WIDTH-1:0] w_fix_hi;
  logic [WIDTH-1:0] w_fix_lo;
  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_div_shift;
  logic [WIDTH+1:0] w_div_diff;
  logic [2*WIDTH:0] w_acc_next;

  assign w_accept   = (r_state == IDLE) && md_start && !md_flush;
  assign w_div_zero = md_is_div(md_op) && (md_b == '0);
  // Dividing the raw dividend by zero unsigned yields all-ones / raw dividend,
  // so clearing the sign flags gives the divide-by-zero result for free.
  assign w_signed   = md_is_signed(md_op) && !w_div_zero;

  md_sign_fix #(.WIDTH(WIDTH)) u_sign_fix (
    .i_a      (md_a),
    .i_b      (md_b),
    .i_signed (w_signed),
    .o_mag_a  (w_mag_a),
    .o_mag_b  (w_mag_b),
    .o_neg_a  (w_neg_a),
    .o_neg_b  (w_neg_b),
    .i_acc    (r_acc[2*WIDTH-1:0]),
    .i_is_div (r_is_div),
    .i_sa     (r_sa),
    .i_sb     (r_sb),
    .o_hi     (w_fix_hi),
    .o_lo     (w_fix_lo)
  );

  always_ff @(posedge clk) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_accept && md_is_iter(md_op)) w_next = CALC;
      CALC:    if (r_cnt == CW'(WIDTH - 1)) w_next = FIX;
      FIX:     w_next = IDLE;
      default: w_next = IDLE;
    endcase
    if (md_flush) w_next = IDLE;
  end

  // Accumulator keeps a spare top bit so the WIDTH+1-bit sum/remainder never truncates.
  // Multiply: [2W:W] partial upper, [W-1:0] multiplier. Divide: [2W:W] remainder, [W-1:0] quotient.
  always_comb begin
    w_mul_sum   = r_acc[2*WIDTH:WIDTH] + (r_acc[0] ? {1'b0, r_mcand} : '0);
    w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_div_diff  = {1'b0, w_div_shift} - {2'b00, r_mcand};
    if (r_is_div) begin
      if (!w_div_diff[WIDTH+1]) w_acc_next = {w_div_diff[WIDTH:0], r_acc[WIDTH-2:0], 1'b1};
      else                      w_acc_next = {w_div_shift, r_acc[WIDTH-2:0], 1'b0};
    end else begin
      w_acc_next = {1'b0, w_mul_sum, r_acc[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_hi     <= '0;
      r_lo     <= '0;
      r_done   <= 1'b0;
      r_cnt    <= '0;
      r_acc    <= '0;
      r_mcand  <= '0;
      r_is_div <= 1'b0;
      r_sa     <= 1'b0;
      r_sb     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (!md_flush) begin
        case (r_state)
          IDLE: begin
            if (w_accept) begin
              if (md_op == MD_MTHI) r_hi <= md_a;
              if (md_op == MD_MTLO) r_lo <= md_a;
              if (md_is_iter(md_op)) begin
                r_is_div <= md_is_div(md_op);
                r_sa     <= w_neg_a;
                r_sb     <= w_neg_b;
                r_cnt    <= '0;
                r_mcand  <= md_is_div(md_op) ? w_mag_b : w_mag_a;
                r_acc    <= {{(WIDTH+1){1'b0}}, (md_is_div(md_op) ? w_mag_a : w_mag_b)};
              end
            end
          end
          CALC: begin
            r_acc <= w_acc_next;
            r_cnt <= r_cnt + CW'(1);
          end
          FIX: begin
            r_hi   <= w_fix_hi;
            r_lo   <= w_fix_lo;
            r_done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  assign md_busy = (r_state != IDLE);
  assign md_done = r_done;
  assign hi      = r_hi;
  assign lo      = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed table, corner sequences, random ops vs arithmetic model.
module tb_mul_div_unit;
  import md_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         resetn;
  logic         md_start;
  logic [2:0]   md_op;
  logic [W-1:0] md_a;
  logic [W-1:0] md_b;
  logic         md_flush;
  logic         md_busy;
  logic         md_done;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  mul_div_unit #(.WIDTH(W)) u_dut (
    .clk      (clk),
    .resetn   (resetn),
    .md_start (md_start),
    .md_op    (md_op),
    .md_a     (md_a),
    .md_b     (md_b),
    .md_flush (md_flush),
    .md_busy  (md_busy),
    .md_done  (md_done),
    .hi       (hi),
    .lo       (lo)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    string       name;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain 64-bit integer arithmetic (C-style truncating division).
  function automatic logic [63:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    p = '0;
    case (op)
      MD_MULT: begin
        sa = $signed(a);
        sb = $signed(b);
        p  = sa * sb;
      end
      MD_MULTU: p = {32'b0, a} * {32'b0, b};
      MD_DIV: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else begin
          sa = $signed(a);
          sb = $signed(b);
          q  = sa / sb;
          r  = sa % sb;
          p  = {r[31:0], q[31:0]};
        end
      end
      MD_DIVU: begin
        if (b == 0) p = {a, 32'hFFFF_FFFF};
        else        p = {a % b, a / b};
      end
      default: p = '0;
    endcase
    return p;
  endfunction

  task automatic do_iter(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] eh, input logic [31:0] el, input string tag);
    int  cyc;
    bit  early;
    @(negedge clk);
    md_start = 1'b1; md_op = op; md_a = a; md_b = b;
    tick();
    md_start = 1'b0;
    cyc   = 0;
    early = 1'b0;
    while (md_busy && cyc < 100) begin
      cyc++;
      if (md_done) early = 1'b1;
      tick();
    end
    chk({tag, " busy_cycles"}, 64'(cyc), 64'd33);
    chk({tag, " done_early"}, 64'(early), 64'd0);
    chk({tag, " done_pulse"}, 64'(md_done), 64'd1);
    chk({tag, " hi"}, 64'(hi), 64'(eh));
    chk({tag, " lo"}, 64'(lo), 64'(el));
    tick();
    chk({tag, " done_once"}, 64'(md_done), 64'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h0000_0000;
      3:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [63:0] exp;
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    int          cyc;

    vecs[0]  = '{MD_MULT,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, "mult_m2x3"};
    vecs[1]  = '{MD_MULTU, 32'hFFFF_FFFE, 32'd3,         32'h0000_0002, 32'hFFFF_FFFA, "multu_fffffffex3"};
    vecs[2]  = '{MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, "div_m7d2"};
    vecs[3]  = '{MD_DIVU,  32'd7,         32'd2,         32'h0000_0001, 32'h0000_0003, "divu_7d2"};
    vecs[4]  = '{MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, "div_min_dm1"};
    vecs[5]  = '{MD_DIVU,  32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF, "divu_by0"};
    vecs[6]  = '{MD_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, "div_m5_by0"};
    vecs[7]  = '{MD_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, "mult_min_sq"};
    vecs[8]  = '{MD_MULT,  32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFF9, "mult_7xm1"};
    vecs[9]  = '{MD_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, "div_7dm2"};
    vecs[10] = '{MD_DIV,   32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, "div_m7dm2"};
    vecs[11] = '{MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu_max_sq"};
    vecs[12] = '{MD_DIVU,  32'hFFFF_FFFF, 32'd1,         32'h0000_0000, 32'hFFFF_FFFF, "divu_max_d1"};

    resetn = 1'b0; md_start = 1'b0; md_flush = 1'b0; md_op = '0; md_a = '0; md_b = '0;
    repeat (2) tick();
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);
    chk("reset busy", 64'(md_busy), 64'd0);
    chk("reset done", 64'(md_done), 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    foreach (vecs[i]) do_iter(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].name);

    // MTHI then MTLO in consecutive cycles
    @(negedge clk);
    md_start = 1'b1; md_op = MD_MTHI; md_a = 32'hA5A5_A5A5;
    tick();
    chk("mthi hi", 64'(hi), 64'hA5A5_A5A5);
    chk("mthi busy", 64'(md_busy), 64'd0);
    chk("mthi done", 64'(md_done), 64'd0);
    md_op = MD_MTLO; md_a = 32'h5A5A_5A5A;
    tick();
    md_start = 1'b0;
    chk("mtlo lo", 64'(lo), 64'h5A5A_5A5A);
    chk("mtlo hi_kept", 64'(hi), 64'hA5A5_A5A5);
    chk("mtlo busy", 64'(md_busy), 64'd0);

    // start while busy must be ignored
    @(negedge clk);
    md_start = 1'b1; md_op = MD_MULT; md_a = 32'd3; md_b = 32'd5;
    tick();
    md_start = 1'b0;
    cyc = 0;
    while (md_busy && cyc < 100) begin
      cyc++;
      if (cyc >= 5 && cyc <= 8) begin
        md_start = 1'b1; md_op = MD_DIVU; md_a = 32'd100; md_b = 32'd7;
      end else begin
        md_start = 1'b0;
      end
      tick();
    end
    md_start = 1'b0;
    chk("busy_start busy_cycles", 64'(cyc), 64'd33);
    chk("busy_start hi", 64'(hi), 64'd0);
    chk("busy_start lo", 64'(lo), 64'd15);
    chk("busy_start done", 64'(md_done), 64'd1);

    // flush mid-operation
    @(negedge clk);
    md_start = 1'b1; md_op = MD_MULT; md_a = 32'hFFFF_FFFF; md_b = 32'hFFFF_FFFF;
    tick();
    md_start = 1'b0;
    repeat (9) tick();
    chk("flush10 busy_before", 64'(md_busy), 64'd1);
    md_flush = 1'b1;
    tick();
    md_flush = 1'b0;
    chk("flush10 busy", 64'(md_busy), 64'd0);
    chk("flush10 done", 64'(md_done), 64'd0);
    chk("flush10 hi", 64'(hi), 64'd0);
    chk("flush10 lo", 64'(lo), 64'd15);
    repeat (40) begin
      if (md_done) chk("flush10 late_done", 64'(md_done), 64'd0);
      tick();
    end
    chk("flush10 lo_after", 64'(lo), 64'd15);

    // flush coinciding with the FIX edge discards the result
    @(negedge clk);
    md_start = 1'b1; md_op = MD_DIVU; md_a = 32'd100; md_b = 32'd7;
    tick();
    md_start = 1'b0;
    repeat (32) tick();
    chk("flushfix busy_before", 64'(md_busy), 64'd1);
    md_flush = 1'b1;
    tick();
    md_flush = 1'b0;
    chk("flushfix busy", 64'(md_busy), 64'd0);
    chk("flushfix done", 64'(md_done), 64'd0);
    chk("flushfix hi", 64'(hi), 64'd0);
    chk("flushfix lo", 64'(lo), 64'd15);
    tick();
    chk("flushfix done_next", 64'(md_done), 64'd0);

    // reset mid-operation abandons the op
    @(negedge clk);
    md_start = 1'b1; md_op = MD_MULTU; md_a = 32'd2; md_b = 32'd3;
    tick();
    md_start = 1'b0;
    repeat (5) tick();
    resetn = 1'b0;
    tick();
    chk("rst_mid hi", 64'(hi), 64'd0);
    chk("rst_mid lo", 64'(lo), 64'd0);
    chk("rst_mid busy", 64'(md_busy), 64'd0);
    chk("rst_mid done", 64'(md_done), 64'd0);
    @(negedge clk);
    resetn = 1'b1;

    for (int k = 0; k < 40; k++) begin
      rop = 3'($urandom_range(0, 3));
      ra  = pick_operand();
      rb  = pick_operand();
      exp = ref_md(rop, ra, rb);
      do_iter(rop, ra, rb, exp[63:32], exp[31:0], $sformatf("rand%0d_op%0d", k, rop));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
